// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state type and command record for the ALU command sequencer.
package alu_pkg;

  localparam logic [3:0] OP_DEC  = 4'b0000;
  localparam logic [3:0] OP_INC  = 4'b0001;
  localparam logic [3:0] OP_NOT  = 4'b0010;
  localparam logic [3:0] OP_NEG  = 4'b0011;
  localparam logic [3:0] OP_SHL  = 4'b0100;
  localparam logic [3:0] OP_SHR  = 4'b0101;
  localparam logic [3:0] OP_GT   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_OR   = 4'b1000;
  localparam logic [3:0] OP_XOR  = 4'b1001;
  localparam logic [3:0] OP_NAND = 4'b1010;
  localparam logic [3:0] OP_NOR  = 4'b1011;
  localparam logic [3:0] OP_SUB  = 4'b1100;
  localparam logic [3:0] OP_ADD  = 4'b1101;
  localparam logic [3:0] OP_MUL  = 4'b1110;
  localparam logic [3:0] OP_DIV  = 4'b1111;

  localparam logic [8:0] ERR_RESULT = 9'h1FF;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  typedef struct packed {
    logic [3:0] opcode;
    logic [7:0] a;
    logic [7:0] b;
    logic       chain;
  } cmd_t;

  localparam int unsigned CMD_W = $bits(cmd_t);

  // Divide by zero never reaches the ALU; it is answered locally with an error response.
  function automatic logic is_reject(cmd_t c);
    return (c.opcode == OP_DIV) && (c.b == 8'h00);
  endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command, ALU and response signals of the sequencer; master is the sequencer's view.
interface alu_cmd_sequencer_if;

  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_opcode;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic       cmd_chain;

  logic [7:0] alu_op1;
  logic [7:0] alu_op2;
  logic [3:0] alu_opcode;
  logic [8:0] alu_result;
  logic       alu_carry;
  logic       alu_zero;

  logic       rsp_valid;
  logic       rsp_ready;
  logic [8:0] rsp_result;
  logic       rsp_carry;
  logic       rsp_zero;
  logic       rsp_err;
  logic       busy;

  modport master (
    input  cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_chain,
    input  alu_result, alu_carry, alu_zero,
    input  rsp_ready,
    output cmd_ready,
    output alu_op1, alu_op2, alu_opcode,
    output rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_err, busy
  );

  modport slave (
    output cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_chain,
    output alu_result, alu_carry, alu_zero,
    output rsp_ready,
    input  cmd_ready,
    input  alu_op1, alu_op2, alu_opcode,
    input  rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_err, busy
  );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO for queued ALU commands; flags derive from the registered count.
module alu_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 21
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Queues ALU commands, issues them one at a time, waits the ALU latency and returns
// results in order, optionally chaining the previous result in as op1.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ALU_LAT = 1
) (
  input logic                 Clock,
  input logic                 Resetn,
  alu_cmd_sequencer_if.master bus
);

  localparam int unsigned CntW   = (ALU_LAT > 1) ? $clog2(ALU_LAT + 1) : 1;
  localparam int unsigned CountW = $clog2(DEPTH + 1);

  state_e            state;
  logic [CntW-1:0]   cnt;
  logic [8:0]        last_result;
  logic [7:0]        op1_q;
  logic [7:0]        op2_q;
  logic [3:0]        opcode_q;
  logic              rsp_valid_q;
  logic [8:0]        rsp_result_q;
  logic              rsp_carry_q;
  logic              rsp_zero_q;
  logic              rsp_err_q;

  cmd_t              wr_cmd;
  cmd_t              head;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [CountW-1:0] fifo_count;
  logic [7:0]        op1_eff;

  assign wr_cmd = '{opcode: bus.cmd_opcode, a: bus.cmd_a, b: bus.cmd_b, chain: bus.cmd_chain};
  assign push   = bus.cmd_valid && !full;
  // Issue only when the response slot is free or is being consumed this cycle.
  assign pop    = !empty && ((state == IDLE) || ((state == RESP) && bus.rsp_ready));
  assign op1_eff = head.chain ? last_result[7:0] : head.a;

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk   (Clock),
    .rst   (Resetn),
    .push  (push),
    .wdata (wr_cmd),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  always_ff @(posedge Clock) begin
    if (Resetn) begin
      state        <= IDLE;
      cnt          <= '0;
      last_result  <= '0;
      op1_q        <= '0;
      op2_q        <= '0;
      opcode_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else if (pop) begin
      if (is_reject(head)) begin
        rsp_result_q <= ERR_RESULT;
        rsp_carry_q  <= 1'b1;
        rsp_zero_q   <= 1'b0;
        rsp_err_q    <= 1'b1;
        rsp_valid_q  <= 1'b1;
        state        <= RESP;
      end else begin
        op1_q       <= op1_eff;
        op2_q       <= head.b;
        opcode_q    <= head.opcode;
        cnt         <= CntW'(ALU_LAT);
        rsp_valid_q <= 1'b0;
        state       <= WAIT;
      end
    end else begin
      unique case (state)
        IDLE: begin
          state <= IDLE;
        end
        WAIT: begin
          if (cnt == '0) begin
            rsp_result_q <= bus.alu_result;
            rsp_carry_q  <= bus.alu_carry;
            rsp_zero_q   <= bus.alu_zero;
            rsp_err_q    <= 1'b0;
            rsp_valid_q  <= 1'b1;
            last_result  <= bus.alu_result;
            state        <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready  = !full;
  assign bus.alu_op1    = op1_q;
  assign bus.alu_op2    = op2_q;
  assign bus.alu_opcode = opcode_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_carry  = rsp_carry_q;
  assign bus.rsp_zero   = rsp_zero_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.busy       = (fifo_count != '0) || (state != IDLE);

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command-side master for the 8-bit ALU. Accepts operation commands on a valid/ready port and queues them in a small FIFO. Drives the ALU operand/opcode inputs one command at a time, waits the ALU's registered latency, then captures the 9-bit result and flags. Returns them in order on a valid/ready response port, with optional chaining of the previous result as the next op1.

## Interface
Parameters:
- DEPTH, 4: command FIFO depth; power of two, ≥2.
- ALU_LAT, 1: clock edges from ALU input change to stable result/flags; ≥1.

Ports:
- Clock  input  1  single clock; all logic on its rising edge.
- Resetn  input  1  reset; synchronous, active-high (asserted = 1).
- cmd_valid  input  1  command present.
- cmd_ready  output  1  FIFO not full.
- cmd_opcode  input  4  ALU opcode.
- cmd_a  input  8  operand 1 (ignored when cmd_chain=1).
- cmd_b  input  8  operand 2.
- cmd_chain  input  1  use last_result[7:0] as op1.
- alu_op1  output  8  to ALU op1.
- alu_op2  output  8  to ALU op2.
- alu_opcode  output  4  to ALU Opcode.
- alu_result  input  9  from ALU Result.
- alu_carry  input  1  from ALU Carry_Flag.
- alu_zero  input  1  from ALU Zero_Flag.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts.
- rsp_result  output  9  captured result.
- rsp_carry  output  1  captured carry.
- rsp_zero  output  1  captured zero.
- rsp_err  output  1  command rejected (divide by zero).
- busy  output  1  FIFO non-empty or FSM not IDLE.

## Operation
- FIFO entry: {opcode, a, b, chain}. Push on cmd_valid && cmd_ready. cmd_ready = !full from registered count; a pop in the same cycle does not bypass. Simultaneous push and pop when not full: count unchanged.
- FSM states: IDLE, WAIT, RESP.
- Issue: pop the head when either FIFO is non-empty and state is IDLE, or FIFO is non-empty and state is RESP with rsp_ready=1.
  - Effective op1 = chain ? last_result[7:0] : a.
  - Normal issue: register alu_op1/alu_op2/alu_opcode, load cnt=ALU_LAT, go to WAIT.
  - Rejected issue (opcode 4'b1111, b=0): leave alu_* outputs unchanged. Load rsp_result=9'h1FF, rsp_carry=1, rsp_zero=0, rsp_err=1, rsp_valid=1, go to RESP. last_result is not updated.
- WAIT: decrement cnt each edge. On the edge where cnt==0, capture alu_result/alu_carry/alu_zero into the rsp_* registers, set rsp_err=0, rsp_valid=1, last_result=alu_result, go to RESP.
- RESP: hold rsp_* stable while rsp_ready=0. When rsp_ready=1, issue the next command if one exists; otherwise clear rsp_valid and go to IDLE.
- alu_* outputs hold their last values between commands.
- Responses are strictly in command order; one command in flight.

## Timing
- Reset (Resetn=1 at an edge): FIFO emptied, state IDLE, last_result=0, cnt=0. All outputs 0 except cmd_ready=1. In-flight and queued commands are dropped with no response.
- ALU_LAT=1, empty system: command accepted at edge a, popped/issued at a+1, captured at a+3. rsp_valid is high after edge a+3.
- Capture edge = issue edge + ALU_LAT + 1.
- Back-to-back throughput: one response per ALU_LAT+2 cycles under continuous rsp_ready.
- Rejected command: rsp_valid is high after the issue edge (1-cycle latency).
- cmd_ready is low exactly while count==DEPTH.

## Structure
- Shared package alu_pkg:
  - opcode localparams OP_DEC … OP_DIV (4'b0000–4'b1111);
  - state enum {IDLE, WAIT, RESP};
  - ERR_RESULT = 9'h1FF.
- Sub-module alu_cmd_fifo: synchronous FIFO, parameters DEPTH and WIDTH=21, with push/pop/full/empty/count.
- FSM, issue mux and response registers live in the top module.

## Test plan
- Add: opcode 1101, a=200, b=100 → rsp_result=9'h12C, carry=1, zero=0; rsp_valid 3 cycles after accept (ALU_LAT=1).
- Chain: increment a=8'hFF → 9'h100; then decrement with chain=1 → op1=8'h00, rsp_result=9'h1FF, carry=1.
- Divide by zero: opcode 1111, a=10, b=0 → rsp_err=1, result 9'h1FF, alu_* unchanged. A following chained add with b=1 uses the previous last_result.
- Full/backpressure: 6 commands back-to-back with rsp_ready=0 → 5 accepted, cmd_ready low from the 6th. Release rsp_ready → 5 responses in order, each held stable while stalled.
- Reset during WAIT: assert Resetn for one edge → rsp_valid never rises, busy=0, cmd_ready=1. The next add of 1+1 returns 9'd2.
- Zero flag: opcode 0110, a=5, b=6 → rsp_result=0, zero=1, carry=0.
